// File: rtl/ltc2308_pkg.sv
// Shared types, constants and helpers for the LTC2308 scan controller.
package ltc2308_pkg;

  localparam int LTC2308_BITS     = 12;
  localparam int LTC2308_CFG_BITS = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CONV  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_ACQ   = 2'd3
  } state_t;

  function automatic logic [LTC2308_CFG_BITS-1:0] cfg_word(input logic [2:0] ch, input logic uni);
    cfg_word = {1'b1, ch[0], ch[2], ch[1], uni, 1'b0};
  endfunction

  // Lowest set bit strictly above cur, wrapping to the lowest set bit; cur=7 yields the lowest.
  function automatic logic [2:0] next_channel(input logic [7:0] mask, input logic [2:0] cur);
    logic [2:0] lowest;
    logic [2:0] above;
    logic       found;
    lowest = 3'd0;
    above  = 3'd0;
    found  = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (mask[i]) begin
        lowest = 3'(i);
        if (i > int'(cur)) begin
          above = 3'(i);
          found = 1'b1;
        end
      end
    end
    next_channel = found ? above : lowest;
  endfunction

endpackage

// File: rtl/ltc2308_spi_frame.sv
// One 12-bit LTC2308 SPI frame: SCK divider, config shift-out, result shift-in.
module ltc2308_spi_frame
  import ltc2308_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [LTC2308_CFG_BITS-1:0] cfg,
  input  logic                        sdo,
  output logic                        sck,
  output logic                        sdi,
  output logic                        done,
  output logic [LTC2308_BITS-1:0]     data
);

  logic        busy;
  logic [15:0] div_cnt;
  logic [3:0]  bit_cnt;
  logic [11:0] tx;
  logic        phase_end;

  assign phase_end = (div_cnt == 16'(CLK_DIV - 1));
  // data is complete once the last high phase ends
  assign done = busy && sck && phase_end && (bit_cnt == 4'd11);

  always_ff @(posedge clk) begin
    if (rst) begin
      busy    <= 1'b0;
      sck     <= 1'b0;
      sdi     <= 1'b0;
      div_cnt <= 16'd0;
      bit_cnt <= 4'd0;
      tx      <= 12'd0;
      data    <= 12'd0;
    end else if (start) begin
      busy    <= 1'b1;
      sck     <= 1'b0;
      sdi     <= cfg[5];
      tx      <= {cfg[4:0], 7'd0};
      div_cnt <= 16'd0;
      bit_cnt <= 4'd0;
    end else if (busy) begin
      if (phase_end) begin
        div_cnt <= 16'd0;
        if (!sck) begin
          sck  <= 1'b1;
          data <= {data[10:0], sdo};
        end else begin
          sck <= 1'b0;
          if (bit_cnt == 4'd11) begin
            busy <= 1'b0;
            sdi  <= 1'b0;
          end else begin
            bit_cnt <= bit_cnt + 4'd1;
            sdi     <= tx[11];
            tx      <= {tx[10:0], 1'b0};
          end
        end
      end else begin
        div_cnt <= div_cnt + 16'd1;
      end
    end
  end

endmodule

// File: rtl/ltc2308_scan.sv
// Round-robin LTC2308 scan controller with channel-tagged results.
// Optional 4-frame averaging is enabled by defining LTC2308_SCAN_AVG_EN.
module ltc2308_scan
  import ltc2308_pkg::*;
#(
  parameter int CLK_DIV     = 2,
  parameter int CONV_CYCLES = 80,
  parameter int ACQ_CYCLES  = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [7:0]  ch_mask,
  input  logic        uni,
  output logic [11:0] sample,
  output logic [2:0]  sample_ch,
  output logic        sample_valid,
  output logic        ADC_CONVST,
  output logic        ADC_SCK,
  output logic        ADC_SDI,
  input  logic        ADC_SDO
);

  state_t      state, state_nx;
  logic [15:0] cnt;
  logic [2:0]  cur_ch, prev_ch, emit_ch, sel_ch;
  logic        prev_valid, emit_valid, cfg_uni;
  logic        go, conv_last, acq_last, conv_entry, from_idle, start, done;
  logic [11:0] frame_data;

  assign go         = enable && (ch_mask != 8'd0);
  assign conv_last  = (cnt == 16'(CONV_CYCLES - 1));
  assign acq_last   = (cnt == 16'(ACQ_CYCLES - 1));
  assign from_idle  = (state == ST_IDLE);
  assign conv_entry = (state_nx == ST_CONV) && (state != ST_CONV);
  assign sel_ch     = next_channel(ch_mask, from_idle ? 3'd7 : cur_ch);

  always_comb begin
    state_nx = state;
    start    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (go) state_nx = ST_CONV;
        else    state_nx = ST_IDLE;
      end
      ST_CONV: begin
        if (conv_last) begin
          state_nx = ST_SHIFT;
          start    = 1'b1;
        end else begin
          state_nx = ST_CONV;
        end
      end
      ST_SHIFT: begin
        if (done) state_nx = ST_ACQ;
        else      state_nx = ST_SHIFT;
      end
      ST_ACQ: begin
        if (acq_last) state_nx = go ? ST_CONV : ST_IDLE;
        else          state_nx = ST_ACQ;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // CONVST mirrors the registered state, so it is high for exactly the CONV cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= 16'd0;
      ADC_CONVST <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= ((state_nx != state) || (state == ST_IDLE)) ? 16'd0 : cnt + 16'd1;
      ADC_CONVST <= (state_nx == ST_CONV);
    end
  end

  ltc2308_spi_frame #(.CLK_DIV(CLK_DIV)) u_frame (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .cfg   (cfg_word(cur_ch, cfg_uni)),
    .sdo   (ADC_SDO),
    .sck   (ADC_SCK),
    .sdi   (ADC_SDI),
    .done  (done),
    .data  (frame_data)
  );

`ifdef LTC2308_SCAN_AVG_EN
  logic [1:0]  rep;
  logic [1:0]  acc_cnt;
  logic [13:0] acc, sum;
  assign sum = acc + {2'b00, frame_data};
`endif

  // Data read in a frame belongs to the channel configured in the frame before
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_ch     <= 3'd0;
      cfg_uni    <= 1'b0;
      prev_ch    <= 3'd0;
      prev_valid <= 1'b0;
      emit_ch    <= 3'd0;
      emit_valid <= 1'b0;
`ifdef LTC2308_SCAN_AVG_EN
      rep        <= 2'd0;
`endif
    end else begin
      if (conv_entry) begin
        cfg_uni <= uni;
        if (from_idle) prev_valid <= 1'b0;
`ifdef LTC2308_SCAN_AVG_EN
        if (from_idle || (rep == 2'd3)) begin
          cur_ch <= sel_ch;
          rep    <= 2'd0;
        end else begin
          rep <= rep + 2'd1;
        end
`else
        cur_ch <= sel_ch;
`endif
      end
      if (start) begin
        emit_ch    <= prev_ch;
        emit_valid <= prev_valid;
      end
      if (done) begin
        prev_ch    <= cur_ch;
        prev_valid <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sample       <= 12'd0;
      sample_ch    <= 3'd0;
      sample_valid <= 1'b0;
`ifdef LTC2308_SCAN_AVG_EN
      acc          <= 14'd0;
      acc_cnt      <= 2'd0;
`endif
    end else begin
`ifdef LTC2308_SCAN_AVG_EN
      sample_valid <= 1'b0;
      if (state == ST_IDLE) begin
        acc     <= 14'd0;
        acc_cnt <= 2'd0;
      end else if (done && emit_valid) begin
        if (acc_cnt == 2'd3) begin
          sample       <= sum[13:2];
          sample_ch    <= emit_ch;
          sample_valid <= 1'b1;
          acc          <= 14'd0;
          acc_cnt      <= 2'd0;
        end else begin
          acc     <= sum;
          acc_cnt <= acc_cnt + 2'd1;
        end
      end
`else
      sample_valid <= done && emit_valid;
      if (done && emit_valid) begin
        sample    <= frame_data;
        sample_ch <= emit_ch;
      end
`endif
    end
  end

endmodule

// File: tb/tb_ltc2308_scan.sv
// Randomised self-checking bench for ltc2308_scan driving a behavioural LTC2308 model.
module tb_ltc2308_scan;

  localparam int CLK_DIV     = 2;
  localparam int CONV_CYCLES = 80;
  localparam int ACQ_CYCLES  = 12;
  localparam int PERIOD      = CONV_CYCLES + 24 * CLK_DIV + ACQ_CYCLES;
  localparam int LAT         = CONV_CYCLES + 24 * CLK_DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        uni = 1'b0;
  logic [7:0]  ch_mask = 8'd0;
  logic [11:0] sample;
  logic [2:0]  sample_ch;
  logic        sample_valid;
  logic        adc_convst, adc_sck, adc_sdi;
  logic        adc_sdo = 1'b0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int     ch;
    int     val;
    longint t;
  } exp_t;
  exp_t exp_q[$];

  int     ref_cur = 0;
  longint last_rise = -1000000;
  bit     restart = 1'b1;
  int     adc_val = 0;
  int     bit_idx = 0;
  int     sck_rises = 0;
  int     cfg_seen = 0;
  int     exp_cfg = 0;
  int     rises = 0;
  int     strobes = 0;
  bit     have_last = 1'b0;
  int     last_sample = 0;
`ifdef LTC2308_SCAN_AVG_EN
  int     rep = 0;
  int     acc_sum = 0;
  int     acc_n = 0;
`endif

  ltc2308_scan #(.CLK_DIV(CLK_DIV), .CONV_CYCLES(CONV_CYCLES), .ACQ_CYCLES(ACQ_CYCLES)) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .ch_mask      (ch_mask),
    .uni          (uni),
    .sample       (sample),
    .sample_ch    (sample_ch),
    .sample_valid (sample_valid),
    .ADC_CONVST   (adc_convst),
    .ADC_SCK      (adc_sck),
    .ADC_SDI      (adc_sdi),
    .ADC_SDO      (adc_sdo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Next selected channel searching upward from cur, wrapping around.
  function automatic int ref_next(input logic [7:0] m, input int cur);
    for (int k = 1; k <= 8; k++) begin
      if (m[(cur + k) % 8]) return (cur + k) % 8;
    end
    return 0;
  endfunction

  function automatic int ref_cfg(input int ch, input int u);
    return 32 + (ch % 2) * 16 + (ch / 4) * 8 + ((ch / 2) % 2) * 4 + u * 2;
  endfunction

  // ADC model: a conversion starts on CONVST rise; its result is read out in this same frame.
  always @(posedge adc_convst) begin
    bit   cont;
    exp_t e;
    cont      = !restart && (($time - last_rise) == longint'(PERIOD * 10));
    restart   = 1'b0;
    last_rise = $time;
    rises++;
    adc_val   = int'($urandom_range(0, 4095));
`ifdef LTC2308_SCAN_AVG_EN
    if (cont) begin
      acc_sum += adc_val;
      acc_n++;
      if (acc_n == 4) begin
        e.ch = ref_cur; e.val = acc_sum / 4; e.t = $time + longint'(LAT * 10);
        exp_q.push_back(e);
        acc_sum = 0;
        acc_n   = 0;
      end
    end
    if (!cont) begin
      ref_cur = ref_next(ch_mask, 7);
      rep = 0; acc_sum = 0; acc_n = 0;
    end else if (rep == 3) begin
      ref_cur = ref_next(ch_mask, ref_cur);
      rep = 0;
    end else begin
      rep++;
    end
`else
    if (cont) begin
      e.ch = ref_cur; e.val = adc_val; e.t = $time + longint'(LAT * 10);
      exp_q.push_back(e);
      ref_cur = ref_next(ch_mask, ref_cur);
    end else begin
      ref_cur = ref_next(ch_mask, 7);
    end
`endif
    exp_cfg   = ref_cfg(ref_cur, int'(uni));
    sck_rises = 0;
    cfg_seen  = 0;
  end

  always @(negedge adc_convst) begin
    bit_idx = 11;
    adc_sdo = adc_val[bit_idx];
  end

  always @(negedge adc_sck) begin
    if (bit_idx > 0) begin
      bit_idx--;
      adc_sdo = adc_val[bit_idx];
    end
  end

  always @(posedge adc_sck) begin
    sck_rises++;
    if (sck_rises <= 6) cfg_seen = cfg_seen * 2 + int'(adc_sdi);
    if (sck_rises == 6) check("cfg_word", cfg_seen, exp_cfg);
  end

  // Result monitor: strobes against the expected queue, plus hold of sample between strobes.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      have_last = 1'b0;
    end else begin
      while (exp_q.size() > 0 && exp_q[0].t < $time - 5) begin
        check("missed_strobe", 0, exp_q[0].t);
        exp_q.delete(0);
      end
      if (sample_valid) begin
        strobes++;
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("sample", sample, e.val);
          check("sample_ch", sample_ch, e.ch);
          check("strobe_time", $time - 5, e.t);
        end
        have_last   = 1'b1;
        last_sample = int'(sample);
      end else if (have_last) begin
        check("sample_hold", sample, last_sample);
      end
    end
  end

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_convst(input logic level);
    int n;
    n = 0;
    while (adc_convst !== level && n < 2 * PERIOD) begin
      @(negedge clk);
      n++;
    end
    if (adc_convst !== level) check("wait_convst", adc_convst, level);
  endtask

  initial begin
    int n_str, n_rise, n;
    run(3);
    check("rst_sample", sample, 0);
    check("rst_sample_ch", sample_ch, 0);
    check("rst_valid", sample_valid, 0);
    check("rst_convst", adc_convst, 0);
    check("rst_sck", adc_sck, 0);
    check("rst_sdi", adc_sdi, 0);
    rst = 1'b0;

    ch_mask = 8'h01; uni = 1'b1; enable = 1'b1;
    run(6 * PERIOD);

    ch_mask = 8'b1010_0100;
    run(7 * PERIOD);

    ch_mask = 8'h03; uni = 1'b0;
    run(3 * PERIOD);
    wait_convst(1'b1);
    wait_convst(1'b0);
    run(5);
    ch_mask = 8'h80;
    run(4 * PERIOD);

    wait_convst(1'b0);
    wait_convst(1'b1);
    run(10);
    enable = 1'b0;
    n_str  = strobes;
    n_rise = rises;
    run(3 * PERIOD);
    check("drop_strobes", strobes, n_str + 1);
    check("drop_no_conv", rises, n_rise);
    check("drop_convst_low", adc_convst, 0);

    for (int i = 0; i < 8; i++) begin
      ch_mask = 8'($urandom_range(0, 255));
      uni     = 1'($urandom_range(0, 1));
      enable  = ($urandom_range(0, 7) != 0);
      run(int'($urandom_range(PERIOD / 2, 3 * PERIOD)));
    end

    ch_mask = 8'h0F; enable = 1'b1; uni = 1'b1;
    wait_convst(1'b1);
    wait_convst(1'b0);
    n = 0;
    while (sck_rises < 6 && n < PERIOD) begin
      @(negedge clk);
      n++;
    end
    check("rst_pre_sck", adc_sck, 1);
    rst = 1'b1; enable = 1'b0; restart = 1'b1;
    while (exp_q.size() > 0 && exp_q[exp_q.size() - 1].t > $time) exp_q.delete(exp_q.size() - 1);
    run(1);
    check("rst_mid_sck", adc_sck, 0);
    check("rst_mid_sdi", adc_sdi, 0);
    check("rst_mid_convst", adc_convst, 0);
    check("rst_mid_valid", sample_valid, 0);
    rst = 1'b0;
    run(2);
    enable = 1'b1;
    run(4 * PERIOD);

    enable = 1'b0;
    run(2 * PERIOD);
    check("queue_empty", exp_q.size(), 0);
    check("strobes_seen", (strobes > 10) ? 1 : 0, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
